sm_serial_addsub: RTL and testbench

Sequential sign-magnitude adder/subtractor. It consumes operands in the same sign-magnitude format (4-bit magnitude plus sign bit) that the combinational subtractor produces. It adds or subtracts them bit-serially, LSB first, through a single 1-bit full adder, and returns a sign-magnitude result with an overflow flag. It sits downstream of the subtractor in the arithmetic datapath, accepts one operation per start/done handshake, and is the first clocked arithmetic block in the ALU group.

---
 rtl/sm_arith_pkg.sv | 15 +
 rtl/sm_serial_addsub_if.sv | 27 ++
 rtl/full_adder_1b.sv | 13 +
 rtl/sm_serial_addsub.sv | 98 +++++++++
 tb/tb_sm_serial_addsub.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/sm_arith_pkg.sv
// Shared definitions for the clocked sign-magnitude arithmetic blocks.
package sm_arith_pkg;

    localparam int WIDTH = 4;             // operand/result magnitude width
    localparam int EXT   = WIDTH + 2;     // internal two's-complement width
    localparam int CNT_W = $clog2(EXT);   // serial bit counter width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CONV  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sm_serial_addsub_if.sv
// Operand/result bundle between a requester and sm_serial_addsub.
interface sm_serial_addsub_if;
    import sm_arith_pkg::*;

    logic             start;
    logic [WIDTH-1:0] A;
    logic             SignoA;
    logic [WIDTH-1:0] B;
    logic             SignoB;
    logic             sel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Resultado;
    logic             Signo;
    logic             Ovf;

    modport master (
        output start, A, SignoA, B, SignoB, sel,
        input  busy, done, Resultado, Signo, Ovf
    );

    modport slave (
        input  start, A, SignoA, B, SignoB, sel,
        output busy, done, Resultado, Signo, Ovf
    );

endinterface

// File: rtl/full_adder_1b.sv
// Single-bit full adder used as the serial arithmetic element.
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/sm_serial_addsub.sv
// Bit-serial sign-magnitude adder/subtractor: converts operands to
// two's complement, adds them LSB first through one full adder, then
// converts the sum back to sign-magnitude with an overflow flag.
module sm_serial_addsub
    import sm_arith_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    sm_serial_addsub_if.slave  bus
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [EXT-1:0]   op_a, op_b, res, mag;
    logic [EXT-1:0]   a_ext, b_ext;
    logic             carry, fa_s, fa_co;

    assign a_ext = {{(EXT-WIDTH){1'b0}}, bus.A};
    assign b_ext = {{(EXT-WIDTH){1'b0}}, bus.B};

    // Magnitude of the finished two's-complement sum (range never reaches -2^(EXT-1)).
    assign mag = res[EXT-1] ? (-res) : res;

    full_adder_1b u_fa (
        .a  (op_a[0]),
        .b  (op_b[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values, independent of block evaluation order.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; start is only honoured from IDLE.
    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_W'(EXT-1)) state_nxt = CONV;
            CONV:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand load, serial add and output conversion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: every datapath register is reset so a post-reset read
            // never exposes stale operands or results from an aborted op.
            op_a          <= '0;
            op_b          <= '0;
            res           <= '0;
            carry         <= 1'b0;
            cnt           <= '0;
            bus.Resultado <= '0;
            bus.Signo     <= 1'b0;
            bus.Ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // -0 negates to 0, so it needs no special case.
                        op_a  <= bus.SignoA ? (-a_ext) : a_ext;
                        op_b  <= (bus.SignoB ^ bus.sel) ? (-b_ext) : b_ext;
                        carry <= 1'b0;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    res   <= {fa_s, res[EXT-1:1]};
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    carry <= fa_co;
                    cnt   <= cnt + 1'b1;
                end
                CONV: begin
                    // A zero sum has a clear MSB, so Signo is 0 for zero.
                    bus.Resultado <= mag[WIDTH-1:0];
                    bus.Signo     <= res[EXT-1];
                    bus.Ovf       <= |mag[EXT-1:WIDTH];
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state == SHIFT) || (state == CONV);
    assign bus.done = (state == DONE);

endmodule

// File: tb/tb_sm_serial_addsub.sv
// Directed and exhaustive checks for sm_serial_addsub.
module tb_sm_serial_addsub;
    import sm_arith_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec  = 0;
    int   n_fail = 0;

    sm_serial_addsub_if bus ();

    sm_serial_addsub dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic       sa;
        logic [3:0] b;
        logic       sb;
        logic       sel;
        logic [3:0] res;
        logic       sign;
        logic       ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int actual, input int expected);
        n_vec++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Issue one operation at the current negedge. Returns packed
    // {Ovf,Signo,Resultado}, cycles from load edge to done, busy seen right
    // after the load edge, and done one cycle after it first rose.
    task automatic do_op(input logic [3:0] a, input logic sa, input logic [3:0] b,
                         input logic sb, input logic sel,
                         output int got, output int lat,
                         output int busy0, output int done_after);
        bus.start  = 1'b1;
        bus.A      = a;
        bus.SignoA = sa;
        bus.B      = b;
        bus.SignoB = sb;
        bus.sel    = sel;
        @(negedge clk);
        bus.start = 1'b0;
        busy0 = int'(bus.busy);
        lat = 0;
        while (!bus.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        got = int'({bus.Ovf, bus.Signo, bus.Resultado});
        @(negedge clk);
        done_after = int'(bus.done);
    endtask

    function automatic int model(input int a, input int sa, input int b,
                                 input int sb, input int sel);
        int va, vb, r, m;
        va = sa ? -a : a;
        vb = (sb ^ sel) ? -b : b;
        r  = va + vb;
        m  = (r < 0) ? -r : r;
        return ((m > 15) ? 32 : 0) + ((r < 0) ? 16 : 0) + (m % 16);
    endfunction

    initial begin
        int got, lat, busy0, done_after, dcount;

        vecs[0] = '{4'd5,  1'b0, 4'd3,  1'b0, 1'b1, 4'd2,  1'b0, 1'b0};
        vecs[1] = '{4'd3,  1'b0, 4'd5,  1'b0, 1'b1, 4'd2,  1'b1, 1'b0};
        vecs[2] = '{4'd7,  1'b1, 4'd8,  1'b1, 1'b0, 4'd15, 1'b1, 1'b0};
        vecs[3] = '{4'd9,  1'b1, 4'd8,  1'b1, 1'b0, 4'd1,  1'b1, 1'b1};
        vecs[4] = '{4'd15, 1'b0, 4'd15, 1'b0, 1'b0, 4'd14, 1'b0, 1'b1};
        vecs[5] = '{4'd0,  1'b1, 4'd0,  1'b0, 1'b0, 4'd0,  1'b0, 1'b0};
        vecs[6] = '{4'd4,  1'b0, 4'd4,  1'b0, 1'b1, 4'd0,  1'b0, 1'b0};
        vecs[7] = '{4'd6,  1'b1, 4'd2,  1'b0, 1'b1, 4'd8,  1'b1, 1'b0};
        vecs[8] = '{4'd15, 1'b1, 4'd15, 1'b0, 1'b1, 4'd14, 1'b1, 1'b1};

        bus.start = 1'b0; bus.A = '0; bus.SignoA = 1'b0;
        bus.B = '0; bus.SignoB = 1'b0; bus.sel = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              int'({bus.busy, bus.done, bus.Ovf, bus.Signo, bus.Resultado}), 0);

        // Directed table
        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].sa, vecs[i].b, vecs[i].sb, vecs[i].sel,
                  got, lat, busy0, done_after);
            check($sformatf("vec%0d_result", i), got,
                  int'({vecs[i].ovf, vecs[i].sign, vecs[i].res}));
            check($sformatf("vec%0d_latency", i), lat, 7);
            check($sformatf("vec%0d_busy_after_load", i), busy0, 1);
            check($sformatf("vec%0d_done_width", i), done_after, 0);
        end

        // start pulsed during SHIFT must be ignored
        bus.start = 1'b1; bus.A = 4'd5; bus.SignoA = 1'b0;
        bus.B = 4'd3; bus.SignoB = 1'b0; bus.sel = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.A = 4'd15; bus.B = 4'd15; bus.sel = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        dcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) dcount++;
        end
        check("ignored_start_done_count", dcount, 1);
        check("ignored_start_result",
              int'({bus.Ovf, bus.Signo, bus.Resultado}), int'(6'b000010));

        // Reset during SHIFT aborts with outputs cleared immediately
        bus.start = 1'b1; bus.A = 4'd15; bus.SignoA = 1'b0;
        bus.B = 4'd15; bus.SignoB = 1'b0; bus.sel = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("mid_reset_outputs",
                 int'({bus.busy, bus.done, bus.Ovf, bus.Signo, bus.Resultado}), 0);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) dcount++;
        end
        check("mid_reset_no_done", dcount, 0);
        do_op(4'd1, 1'b0, 4'd1, 1'b0, 1'b0, got, lat, busy0, done_after);
        check("after_reset_1p1", got, int'(6'b000010));
        check("after_reset_latency", lat, 7);

        // Exhaustive sweep, back-to-back
        for (int a = 0; a < 16; a++)
            for (int sa = 0; sa < 2; sa++)
                for (int b = 0; b < 16; b++)
                    for (int sb = 0; sb < 2; sb++)
                        for (int sel = 0; sel < 2; sel++) begin
                            do_op(4'(a), 1'(sa), 4'(b), 1'(sb), 1'(sel),
                                  got, lat, busy0, done_after);
                            if (lat != 7)
                                check($sformatf("sweep_lat_a%0d_%0d_b%0d_%0d_s%0d",
                                                a, sa, b, sb, sel), lat, 7);
                            check($sformatf("sweep_a%0d_%0d_b%0d_%0d_s%0d",
                                            a, sa, b, sb, sel),
                                  got, model(a, sa, b, sb, sel));
                        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
